// File: rtl/vga_sprite_engine.sv
// 640x480 VGA timing with NSPRITES RGB565 sprites from a shared ROM, composited over a background colour.
// Define VGA_SPRITE_SHADOW_EN to buffer register writes and apply them together at the start of vertical blank.
module vga_sprite_engine #(
  parameter int          NSPRITES  = 4,
  parameter int          NIMAGES   = 4,
  parameter int          SPRITE_W  = 32,
  parameter int          SPRITE_H  = 32,
  parameter int          ROM_AW    = 12,
  parameter int          ADDR_W    = 5,
  parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       writedata,
  input  logic              write,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);

  localparam logic [10:0] H_ACTIVE     = 11'd1280;
  localparam logic [10:0] H_SYNC_START = 11'd1312;
  localparam logic [10:0] H_SYNC_END   = 11'd1504;
  localparam logic [10:0] H_TOTAL      = 11'd1600;
  localparam logic [9:0]  V_ACTIVE     = 10'd480;
  localparam logic [9:0]  V_SYNC_START = 10'd490;
  localparam logic [9:0]  V_SYNC_END   = 10'd492;
  localparam logic [9:0]  V_TOTAL      = 10'd525;
  localparam logic [31:0] IMG_WORDS    = 32'(SPRITE_W * SPRITE_H);
  localparam logic [31:0] ROW_WORDS    = 32'(SPRITE_W);
  localparam logic [ADDR_W-1:0] BG_ADDR = ADDR_W'(4 * NSPRITES);

  logic [10:0] hcount;
  logic [9:0]  vcount;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_TOTAL - 11'd1) begin
      hcount <= '0;
      vcount <= (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  // Register file as seen by the bus; with shadowing these are the shadow copies
  logic [9:0]          x_w   [NSPRITES];
  logic [9:0]          y_w   [NSPRITES];
  logic [3:0]          img_w [NSPRITES];
  logic [NSPRITES-1:0] en_w;
  logic [15:0]         bg_w;
  logic                wr_en;

  assign wr_en = chipselect && write;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSPRITES; i++) begin
        x_w[i]   <= '0;
        y_w[i]   <= '0;
        img_w[i] <= '0;
      end
      en_w <= '0;
      bg_w <= 16'h0010;
    end else if (wr_en) begin
      for (int i = 0; i < NSPRITES; i++) begin
        if (address[ADDR_W-1:2] == (ADDR_W-2)'(i)) begin
          case (address[1:0])
            2'd0: x_w[i] <= writedata[9:0];
            2'd1: y_w[i] <= writedata[9:0];
            2'd2: begin
              en_w[i]  <= writedata[0];
              img_w[i] <= writedata[7:4];
            end
            default: ;
          endcase
        end
      end
      if (address == BG_ADDR)
        bg_w <= writedata;
    end
  end

  logic [9:0]          x_a   [NSPRITES];
  logic [9:0]          y_a   [NSPRITES];
  logic [3:0]          img_a [NSPRITES];
  logic [NSPRITES-1:0] en_a;
  logic [15:0]         bg_a;

`ifdef VGA_SPRITE_SHADOW_EN
  // Whole register set swaps in one clk at the first line of vertical blank
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSPRITES; i++) begin
        x_a[i]   <= '0;
        y_a[i]   <= '0;
        img_a[i] <= '0;
      end
      en_a <= '0;
      bg_a <= 16'h0010;
    end else if (hcount == 11'd0 && vcount == V_ACTIVE) begin
      x_a   <= x_w;
      y_a   <= y_w;
      img_a <= img_w;
      en_a  <= en_w;
      bg_a  <= bg_w;
    end
  end
`else
  assign x_a   = x_w;
  assign y_a   = y_w;
  assign img_a = img_w;
  assign en_a  = en_w;
  assign bg_a  = bg_w;
`endif

  logic [10:0]         col11;
  logic [10:0]         row11;
  logic [NSPRITES-1:0] hit;
  logic                hit_any;
  logic [31:0]         addr_s0;

  assign col11 = {2'b00, hcount[10:1]};
  assign row11 = {1'b0, vcount};

  always_comb begin
    hit = '0;
    for (int i = 0; i < NSPRITES; i++)
      hit[i] = en_a[i] && ({28'b0, img_a[i]} < 32'(NIMAGES))
            && (col11 >= {1'b0, x_a[i]}) && (col11 < {1'b0, x_a[i]} + 11'(SPRITE_W))
            && (row11 >= {1'b0, y_a[i]}) && (row11 < {1'b0, y_a[i]} + 11'(SPRITE_H));
  end

  // Walk from the highest slot down so the lowest hitting index is left standing
  always_comb begin
    hit_any = 1'b0;
    addr_s0 = '0;
    for (int i = NSPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        addr_s0 = 32'(img_a[i]) * IMG_WORDS
                + 32'(10'(vcount - y_a[i])) * ROW_WORDS
                + 32'(10'(hcount[10:1] - x_a[i]));
      end
    end
  end

  logic        hs_raw, vs_raw, blank_raw;
  logic        hit_s1, hit_s2;
  logic [15:0] bg_s1, bg_s2;
  logic [1:0]  hs_d, vs_d, blank_d, clk_d;
  logic [15:0] pix;

  assign hs_raw    = !(hcount >= H_SYNC_START && hcount < H_SYNC_END);
  assign vs_raw    = !(vcount >= V_SYNC_START && vcount < V_SYNC_END);
  assign blank_raw = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
  assign pix       = (hit_s2 && rom_data != KEY_COLOR) ? rom_data : bg_s2;

  // Sync and blank travel alongside the pixel through the same three stages
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr    <= '0;
      hit_s1      <= 1'b0;
      hit_s2      <= 1'b0;
      bg_s1       <= '0;
      bg_s2       <= '0;
      hs_d        <= 2'b11;
      vs_d        <= 2'b11;
      blank_d     <= 2'b00;
      clk_d       <= 2'b00;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
      VGA_CLK     <= 1'b0;
    end else begin
      rom_addr    <= addr_s0[ROM_AW-1:0];
      hit_s1      <= hit_any;
      bg_s1       <= bg_a;
      hit_s2      <= hit_s1;
      bg_s2       <= bg_s1;
      hs_d        <= {hs_d[0], hs_raw};
      vs_d        <= {vs_d[0], vs_raw};
      blank_d     <= {blank_d[0], blank_raw};
      clk_d       <= {clk_d[0], hcount[0]};
      VGA_HS      <= hs_d[1];
      VGA_VS      <= vs_d[1];
      VGA_BLANK_n <= blank_d[1];
      VGA_CLK     <= clk_d[1];
      if (blank_d[1]) begin
        VGA_R <= {pix[15:11], pix[15:13]};
        VGA_G <= {pix[10:5], pix[10:9]};
        VGA_B <= {pix[4:0], pix[4:2]};
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

  assign VGA_SYNC_n = 1'b0;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Randomized bench for vga_sprite_engine: a pixel-level reference model feeds a 3-deep expected-output queue.
module tb_vga_sprite_engine;

  localparam int          NSPRITES  = 4;
  localparam int          NIMAGES   = 4;
  localparam int          SPRITE_W  = 32;
  localparam int          SPRITE_H  = 32;
  localparam int          ROM_AW    = 12;
  localparam int          ADDR_W    = 5;
  localparam logic [15:0] KEY_COLOR = 16'hF81F;
  localparam logic [28:0] RESET_WORD = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       writedata;
  logic              write;
  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [7:0]        VGA_R, VGA_G, VGA_B;
  logic              VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  always #10 clk = ~clk;

  vga_sprite_engine #(
    .NSPRITES(NSPRITES), .NIMAGES(NIMAGES), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
    .ROM_AW(ROM_AW), .ADDR_W(ADDR_W), .KEY_COLOR(KEY_COLOR)
  ) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .rom_addr(rom_addr), .rom_data(rom_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  // ROM holds its own address as data, except every 7th word is the transparent key
  function automatic logic [15:0] rom_word(input int a);
    return (a % 7 == 3) ? KEY_COLOR : 16'(a);
  endfunction

  always @(posedge clk) rom_data <= rom_word(int'(rom_addr));

  int m_x [NSPRITES], m_y [NSPRITES], m_img [NSPRITES], m_en [NSPRITES];
  int m_bg;
  int s_x [NSPRITES], s_y [NSPRITES], s_img [NSPRITES], s_en [NSPRITES];
  int s_bg;
  int pix;
  int checks;
  int errors;
  logic [28:0] exp_q [$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h (pixel index %0d)", tag, got, want, pix);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NSPRITES; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_img[i] = 0; m_en[i] = 0;
      s_x[i] = 0; s_y[i] = 0; s_img[i] = 0; s_en[i] = 0;
    end
    m_bg = 16;
    s_bg = 16;
  endfunction

  function automatic void model_write(input int a, input int d);
    int i, f;
    i = a / 4;
    f = a % 4;
`ifdef VGA_SPRITE_SHADOW_EN
    if (a < 4 * NSPRITES) begin
      if (f == 0) s_x[i] = d % 1024;
      if (f == 1) s_y[i] = d % 1024;
      if (f == 2) begin s_en[i] = d % 2; s_img[i] = (d / 16) % 16; end
    end else if (a == 4 * NSPRITES) s_bg = d % 65536;
`else
    if (a < 4 * NSPRITES) begin
      if (f == 0) m_x[i] = d % 1024;
      if (f == 1) m_y[i] = d % 1024;
      if (f == 2) begin m_en[i] = d % 2; m_img[i] = (d / 16) % 16; end
    end else if (a == 4 * NSPRITES) m_bg = d % 65536;
`endif
  endfunction

  function automatic void model_pixel(input int p, output logic [28:0] word, output bit hit, output int addr);
    int h, v, col, row, color, r5, g6, b5, r8, g8, b8;
    bit active;
    h = p % 1600;
    v = (p / 1600) % 525;
    col = h / 2;
    row = v;
    hit = 0;
    addr = 0;
    for (int i = 0; i < NSPRITES; i++) begin
      if (!hit && m_en[i] != 0 && m_img[i] < NIMAGES &&
          col >= m_x[i] && col < m_x[i] + SPRITE_W && row >= m_y[i] && row < m_y[i] + SPRITE_H) begin
        hit = 1;
        addr = (m_img[i] * SPRITE_W * SPRITE_H + (row - m_y[i]) * SPRITE_W + (col - m_x[i])) % (1 << ROM_AW);
      end
    end
    color = (hit && rom_word(addr) != KEY_COLOR) ? int'(rom_word(addr)) : m_bg;
    active = (h < 1280) && (v < 480);
    r5 = (color / 2048) % 32;
    g6 = (color / 32) % 64;
    b5 = color % 32;
    r8 = active ? r5 * 8 + r5 / 4 : 0;
    g8 = active ? g6 * 4 + g6 / 16 : 0;
    b8 = active ? b5 * 8 + b5 / 4 : 0;
    word = {8'(r8), 8'(g8), 8'(b8), !(h >= 1312 && h <= 1503), !(v == 490 || v == 491),
            active, 1'(h % 2), 1'b0};
  endfunction

  // One clock: drive inputs, predict the pixel now in the counters, step the model across the edge
  task automatic applyStimulus(input bit rst, input bit cs, input bit wr, input int a, input int d);
    logic [28:0] w;
    bit hit;
    int addr;
    hit = 0;
    addr = 0;
    reset = rst;
    chipselect = cs;
    write = wr;
    address = ADDR_W'(a);
    writedata = 16'(d);
    if (!rst) begin
      model_pixel(pix, w, hit, addr);
      exp_q.push_back(w);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      repeat (3) exp_q.push_back(RESET_WORD);
      pix = 0;
      model_reset();
      checkOutput("rom_addr_reset", 32'(rom_addr), 32'd0);
    end else begin
`ifdef VGA_SPRITE_SHADOW_EN
      if (pix % 1600 == 0 && (pix / 1600) % 525 == 480) begin
        m_x = s_x; m_y = s_y; m_img = s_img; m_en = s_en; m_bg = s_bg;
      end
`endif
      if (cs && wr) model_write(a, d);
      pix++;
      if (hit) checkOutput("rom_addr", 32'(rom_addr), 32'(addr));
    end
    checkOutput("pins", 32'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK, VGA_SYNC_n}),
                32'(exp_q.pop_front()));
    reset = 1'b0;
    chipselect = 1'b0;
    write = 1'b0;
    @(negedge clk);
  endtask

  task automatic random_write();
    int a, d;
    a = $urandom_range(0, 31);
    if (a < 16 && a % 4 == 0) d = $urandom_range(0, 660) + $urandom_range(0, 63) * 1024;
    else if (a < 16 && a % 4 == 1) d = $urandom_range(0, 20) + $urandom_range(0, 63) * 1024;
    else if (a < 16 && a % 4 == 2)
      d = ($urandom_range(0, 3) != 0 ? 1 : 0) + $urandom_range(0, 5) * 16 + $urandom_range(0, 255) * 256;
    else d = $urandom_range(0, 65535);
    applyStimulus(1'b0, $urandom_range(0, 7) != 0, 1'b1, a, d);
  endtask

  task automatic run_random(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      if ($urandom_range(0, 149) == 0) random_write();
      else applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pix = 0;
    reset = 1'b1;
    write = 1'b0;
    chipselect = 1'b0;
    address = '0;
    writedata = '0;
    model_reset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    repeat (1700) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    // Overlapping sprites 0/1, a right-edge clip, an out-of-range image and a new background
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 16'h0011);
    applyStimulus(1'b0, 1'b1, 1'b1, 4, 110);
    applyStimulus(1'b0, 1'b1, 1'b1, 5, 5);
    applyStimulus(1'b0, 1'b1, 1'b1, 6, 16'h0021);
    applyStimulus(1'b0, 1'b1, 1'b1, 8, 630);
    applyStimulus(1'b0, 1'b1, 1'b1, 9, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 10, 16'h0031);
    applyStimulus(1'b0, 1'b1, 1'b1, 14, 16'h0051);
    applyStimulus(1'b0, 1'b1, 1'b1, 16, 16'h07E0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 20, 16'h1234);
    repeat (1600 * 10) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 16'h0010);
    repeat (1600 * 2) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

    run_random(1600 * 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    run_random(1600 * 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
